work_frame_assembler: RTL and testbench
=======================================

// Module: work_frame_assembler
// PURPOSE
//  Builds 640-bit mining work units from the host serial byte stream and hands them to the
//  work handler over the new_work / work_data interface. Sits between the UART receiver and the
//  work handler: frame sync, checksum check, inter-byte timeout, and a stable output register.
//  Partial or corrupt frames never reach the work handler.
// PARAMETERS
//  WORK_BYTES      80          payload bytes per frame (640 bits)
//  SOF_BYTE        8'hA5       start-of-frame marker
//  TIMEOUT_CYCLES  5_000_000   max idle clk cycles between bytes inside a frame (100 ms at 50 MHz)
// PORTS
//  clk          in   1    system clock; single clock domain
//  rst          in   1    synchronous, active-high reset
//  rx_data      in   8    received byte from UART receiver
//  new_rx_data  in   1    1-cycle strobe: rx_data valid this cycle
//  new_work     out  1    1-cycle pulse: work_data holds a freshly verified work unit
//  work_data    out  640  last verified work unit; payload byte 0 in [639:632], byte 79 in [7:0]
//  checksum_err out  1    1-cycle pulse: frame dropped, checksum mismatch
//  timeout_err  out  1    1-cycle pulse: frame dropped, inter-byte timeout
//  busy         out  1    high while a frame is in progress (state != IDLE)
//  frame_cnt    out  8    count of accepted frames, wraps 255 -> 0
// BEHAVIOUR
//  Reset: state IDLE; new_work, checksum_err, timeout_err, busy = 0; work_data = 0; frame_cnt = 0;
//   shift register, byte counter, checksum accumulator, timer cleared. Reset mid-frame discards it.
//  Frame on wire: SOF_BYTE, WORK_BYTES payload bytes, 1 checksum byte = XOR of all payload bytes.
//  FSM:
//   IDLE    : strobe with rx_data == SOF_BYTE -> PAYLOAD (cnt=0, chk=0, timer=0); other bytes ignored.
//   PAYLOAD : each strobe: shreg <= {shreg[631:0], rx_data}; chk ^= rx_data; cnt++; timer=0.
//             Strobe with cnt == WORK_BYTES-1 -> CHECK. SOF_BYTE value inside payload is data.
//   CHECK   : strobe: rx_data == chk -> commit; else checksum_err pulse. Either way -> IDLE.
//  Commit: in cycle after checksum strobe, work_data <= shreg, new_work = 1, frame_cnt++ (mod 256).
//   work_data changes only on commit; stays stable during assembly of the next frame.
//  Timeout: in PAYLOAD/CHECK, timer increments each cycle without strobe; on reaching
//   TIMEOUT_CYCLES-1 -> timeout_err pulse next cycle, -> IDLE, partial frame discarded.
//   Strobe in the same cycle as expiry: byte is consumed, timer restarts, no error.
//  Pulses (new_work, checksum_err, timeout_err) are exactly 1 cycle and mutually exclusive.
//  Back-to-back strobes on consecutive cycles are accepted without loss. A SOF strobe in the cycle
//   the FSM returns to IDLE starts a new frame.
//  Widths: cnt 7 bits ($clog2(WORK_BYTES)); timer $clog2(TIMEOUT_CYCLES) bits, saturating-free.
// STRUCTURE
//  Shared package: SOF_BYTE, WORK_BYTES, WORK_BITS (= 8*WORK_BYTES), FSM state encoding
//   (IDLE/PAYLOAD/CHECK), also used by the host-side frame encoder model in the bench.
//  One sub-module: byte_timeout_timer (clear, enable, expired pulse; TIMEOUT_CYCLES param).
//  Top: FSM, 640-bit shift register, XOR accumulator, output register, frame counter.
// TESTING
//  T1 SOF, bytes 0x00..0x4F, chk 0x00 -> new_work 1 cycle, work_data[639:632]=0x00,[7:0]=0x4F, frame_cnt=1.
//  T2 same frame, chk 0x01 -> checksum_err 1 cycle, no new_work, work_data unchanged from T1.
//  T3 SOF + 40 bytes, then silence TIMEOUT_CYCLES (bench param 100) -> timeout_err; then valid frame -> accepted.
//  T4 garbage bytes 0x11,0x22 then SOF frame whose payload contains 0xA5 -> accepted, 0xA5 kept as data.
//  T5 rst asserted mid-payload (byte 30) -> all outputs 0, busy 0; next full frame accepted, frame_cnt=1.
//  T6 256 valid frames back-to-back (1-cycle gaps) -> 256 new_work pulses, frame_cnt wraps to 0.

Source files
------------

// File: rtl/work_frame_assembler_pkg.sv
// work_frame_assembler_pkg: frame constants and FSM encoding shared by RTL and host-side models
package work_frame_assembler_pkg;
    localparam int WORK_BYTES = 80;
    localparam int WORK_BITS = 8 * WORK_BYTES;
    localparam int CNT_W = $clog2(WORK_BYTES);
    localparam logic [7:0] SOF_BYTE = 8'hA5;
    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;
endpackage

// File: rtl/work_frame_assembler_if.sv
// work_frame_assembler_if: byte stream in, verified work unit and status out
interface work_frame_assembler_if;
    import work_frame_assembler_pkg::*;
    logic [7:0] rx_data;
    logic new_rx_data;
    logic new_work;
    logic [WORK_BITS-1:0] work_data;
    logic checksum_err;
    logic timeout_err;
    logic busy;
    logic [7:0] frame_cnt;
    modport master (
        output rx_data, new_rx_data,
        input  new_work, work_data, checksum_err, timeout_err, busy, frame_cnt
    );
    modport slave (
        input  rx_data, new_rx_data,
        output new_work, work_data, checksum_err, timeout_err, busy, frame_cnt
    );
endinterface

// File: rtl/work_frame_assembler_byte_timeout_timer.sv
// byte_timeout_timer: counts idle cycles, flags the idle cycle that reaches TIMEOUT_CYCLES-1
module byte_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [W-1:0] count;
    assign expired = enable && !clear && count == W'(TIMEOUT_CYCLES - 1);
    // a clear (byte arrival or idle FSM) always wins over expiry
    always_ff @(posedge clk) begin
        if (rst || clear) count <= '0;
        else if (enable) count <= count + 1'b1;
    end
endmodule

// File: rtl/work_frame_assembler.sv
// work_frame_assembler: frames host bytes into checksum-verified 640-bit work units
module work_frame_assembler
    import work_frame_assembler_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input logic clk,
    input logic rst,
    work_frame_assembler_if.slave bus
);
    state_t state_q, state_d;
    logic [WORK_BITS-1:0] shreg;
    logic [7:0] chk;
    logic [CNT_W-1:0] cnt;
    logic shift, commit, bad, expired;

    byte_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk(clk),
        .rst(rst),
        .clear(bus.new_rx_data || state_q == IDLE),
        .enable(state_q != IDLE),
        .expired(expired)
    );

    assign bus.busy = state_q != IDLE;

    // next state and per-cycle datapath actions
    always_comb begin
        state_d = state_q;
        shift = 1'b0;
        commit = 1'b0;
        bad = 1'b0;
        case (state_q)
            IDLE: state_d = (bus.new_rx_data && bus.rx_data == SOF_BYTE) ? PAYLOAD : IDLE;
            PAYLOAD: begin
                shift = bus.new_rx_data;
                state_d = bus.new_rx_data ? ((cnt == CNT_W'(WORK_BYTES - 1)) ? CHECK : PAYLOAD)
                                          : (expired ? IDLE : PAYLOAD);
            end
            CHECK: begin
                commit = bus.new_rx_data && bus.rx_data == chk;
                bad = bus.new_rx_data && bus.rx_data != chk;
                state_d = (bus.new_rx_data || expired) ? IDLE : CHECK;
            end
            default: state_d = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end

    // payload assembly, checksum accumulation, output register and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            chk <= '0;
            cnt <= '0;
            bus.work_data <= '0;
            bus.frame_cnt <= '0;
            bus.new_work <= 1'b0;
            bus.checksum_err <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            bus.new_work <= commit;
            bus.checksum_err <= bad;
            bus.timeout_err <= expired;
            if (state_q == IDLE) begin
                chk <= '0;
                cnt <= '0;
            end
            if (shift) begin
                shreg <= {shreg[WORK_BITS-9:0], bus.rx_data};
                chk <= chk ^ bus.rx_data;
                cnt <= cnt + 1'b1;
            end
            if (commit) begin
                bus.work_data <= shreg;
                bus.frame_cnt <= bus.frame_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_work_frame_assembler.sv
// tb_work_frame_assembler: directed frames with a scoreboard of expected output pulses
module tb_work_frame_assembler;
    import work_frame_assembler_pkg::*;
    localparam int TMO = 100;
    localparam int W = WORK_BITS;
    typedef enum int {K_WORK, K_CSUM, K_TMO} kind_t;
    typedef struct {
        kind_t kind;
        logic [W-1:0] work;
        logic [7:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    work_frame_assembler_if bus();
    work_frame_assembler #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    exp_t q[$];
    exp_t e;
    int checks = 0;
    int errors = 0;
    int nw_seen = 0;
    int nw_start;
    logic [7:0] pay [WORK_BYTES];
    logic [W-1:0] exp_work = '0;
    logic [7:0] exp_cnt = '0;

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] pack_work();
        logic [W-1:0] w = '0;
        for (int i = 0; i < WORK_BYTES; i++) w = {w[W-9:0], pay[i]};
        return w;
    endfunction

    function automatic logic [7:0] xsum();
        logic [7:0] x = '0;
        for (int i = 0; i < WORK_BYTES; i++) x ^= pay[i];
        return x;
    endfunction

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(logic [7:0] b);
        bus.rx_data = b;
        bus.new_rx_data = 1'b1;
        tick(1);
        bus.new_rx_data = 1'b0;
    endtask

    task automatic send_frame(logic [7:0] c, int gap, int hold_at, int hold_len);
        if (c == xsum()) begin
            exp_work = pack_work();
            exp_cnt++;
            q.push_back('{K_WORK, exp_work, exp_cnt});
        end else begin
            q.push_back('{K_CSUM, exp_work, exp_cnt});
        end
        send(SOF_BYTE);
        tick(gap);
        for (int i = 0; i < WORK_BYTES; i++) begin
            if (i == hold_at) tick(hold_len);
            send(pay[i]);
            tick(gap);
        end
        send(c);
        tick(gap);
    endtask

    task automatic wait_drain(string name, int limit);
        int n = 0;
        while (q.size() != 0 && n < limit) begin
            tick(1);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected pulses still pending, required 0", name, q.size());
            q.delete();
        end
        tick(2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        exp_work = '0;
        exp_cnt = '0;
        q.delete();
    endtask

    // monitor: every output pulse must match the oldest expected event
    always @(negedge clk) begin
        if (!rst && (bus.new_work || bus.checksum_err || bus.timeout_err)) begin
            if (bus.new_work) nw_seen++;
            if (int'(bus.new_work) + int'(bus.checksum_err) + int'(bus.timeout_err) > 1) begin
                checks++;
                errors++;
                $display("FAIL pulse_excl: got nw=%0b ce=%0b te=%0b required one-hot",
                         bus.new_work, bus.checksum_err, bus.timeout_err);
            end else if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got nw=%0b ce=%0b te=%0b required none",
                         bus.new_work, bus.checksum_err, bus.timeout_err);
            end else begin
                e = q.pop_front();
                check("pulse_kind", W'(bus.new_work ? K_WORK : bus.checksum_err ? K_CSUM : K_TMO), W'(e.kind));
                check("pulse_work_data", bus.work_data, e.work);
                check("pulse_frame_cnt", W'(bus.frame_cnt), W'(e.cnt));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_data = '0;
        bus.new_rx_data = 1'b0;
        tick(2);
        do_reset();
        check("rst_busy", W'(bus.busy), '0);
        check("rst_new_work", W'(bus.new_work), '0);
        check("rst_errs", W'({bus.checksum_err, bus.timeout_err}), '0);
        check("rst_work_data", bus.work_data, '0);
        check("rst_frame_cnt", W'(bus.frame_cnt), '0);

        // T1: incrementing payload, checksum 0x00
        for (int i = 0; i < WORK_BYTES; i++) pay[i] = 8'(i);
        send_frame(8'h00, 0, -1, 0);
        wait_drain("t1_drain", 10);
        check("t1_byte0", W'(bus.work_data[639:632]), W'(8'h00));
        check("t1_byte79", W'(bus.work_data[7:0]), W'(8'h4F));
        check("t1_frame_cnt", W'(bus.frame_cnt), W'(8'd1));
        check("t1_busy", W'(bus.busy), '0);

        // T2: same payload, bad checksum
        send_frame(8'h01, 0, -1, 0);
        wait_drain("t2_drain", 10);
        check("t2_byte79_kept", W'(bus.work_data[7:0]), W'(8'h4F));
        check("t2_frame_cnt", W'(bus.frame_cnt), W'(8'd1));

        // T3: SOF + 40 bytes then silence
        q.push_back('{K_TMO, exp_work, exp_cnt});
        send(SOF_BYTE);
        for (int i = 0; i < 40; i++) send(pay[i]);
        tick(TMO - 1);
        check("t3_busy_before_expiry", W'(bus.busy), W'(1'b1));
        check("t3_no_early_timeout", W'(q.size()), W'(1));
        wait_drain("t3_timeout", 5);
        check("t3_busy_after", W'(bus.busy), '0);
        // byte arriving exactly in the expiry cycle is consumed
        for (int i = 0; i < WORK_BYTES; i++) pay[i] = 8'(8'hFF - i);
        send_frame(xsum(), 0, 10, TMO - 1);
        wait_drain("t3_edge_frame", 10);
        check("t3_byte0", W'(bus.work_data[639:632]), W'(8'hFF));
        check("t3_byte79", W'(bus.work_data[7:0]), W'(8'hB0));
        check("t3_frame_cnt", W'(bus.frame_cnt), W'(8'd2));

        // T4: garbage before SOF, 0xA5 inside payload
        send(8'h11);
        send(8'h22);
        for (int i = 0; i < WORK_BYTES; i++) pay[i] = 8'(i * 7);
        pay[0] = 8'hA5;
        pay[40] = 8'hA5;
        send_frame(xsum(), 0, -1, 0);
        wait_drain("t4_drain", 10);
        check("t4_byte0_sof_data", W'(bus.work_data[639:632]), W'(8'hA5));
        check("t4_byte40_sof_data", W'(bus.work_data[319:312]), W'(8'hA5));
        check("t4_byte79", W'(bus.work_data[7:0]), W'(8'h29));
        check("t4_frame_cnt", W'(bus.frame_cnt), W'(8'd3));

        // T5: reset mid-payload
        send(SOF_BYTE);
        for (int i = 0; i < 30; i++) send(pay[i]);
        rst = 1'b1;
        tick(1);
        check("t5_busy", W'(bus.busy), '0);
        check("t5_work_data", bus.work_data, '0);
        check("t5_frame_cnt", W'(bus.frame_cnt), '0);
        check("t5_pulses", W'({bus.new_work, bus.checksum_err, bus.timeout_err}), '0);
        rst = 1'b0;
        exp_work = '0;
        exp_cnt = '0;
        q.delete();
        for (int i = 0; i < WORK_BYTES; i++) pay[i] = 8'(i + 1);
        send_frame(xsum(), 0, -1, 0);
        wait_drain("t5_drain", 10);
        check("t5_frame_cnt_after", W'(bus.frame_cnt), W'(8'd1));

        // T6: 256 frames with 1-cycle gaps, counter wraps
        do_reset();
        nw_start = nw_seen;
        for (int f = 0; f < 256; f++) begin
            for (int i = 0; i < WORK_BYTES; i++) pay[i] = 8'(i ^ f);
            send_frame(xsum(), 1, -1, 0);
        end
        wait_drain("t6_drain", 20);
        check("t6_new_work_count", W'(nw_seen - nw_start), W'(256));
        check("t6_frame_cnt_wrap", W'(bus.frame_cnt), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
